// File: rtl/dv_test_status_sig_pkg.sv
// Shared definitions for the DV test-status signature.
// The detector matches against these strings, and the status printer
// prints its banners from the same constants, so the two ends always agree
// on the exact text.
package dv_test_status_sig_pkg;

  localparam int SigLen    = 18;
  localparam int BranchPos = 5;  // 'P' or 'F' decides which signature applies

  // Element 0 holds the first character of the line.
  localparam logic [0:SigLen-1][7:0] SigPass = "TEST PASSED CHECKS";
  localparam logic [0:SigLen-1][7:0] SigFail = "TEST FAILED CHECKS";

  localparam logic [7:0] AsciiLf = 8'h0a;
  localparam logic [7:0] AsciiCr = 8'h0d;

  localparam logic BrPass = 1'b0;
  localparam logic BrFail = 1'b1;

  typedef enum logic [1:0] {
    LINE_START,
    MATCH,
    CONFIRM,
    SKIP_LINE
  } det_state_e;

  function automatic logic [7:0] sig_char(input logic br, input logic [4:0] idx);
    sig_char = br ? SigFail[idx] : SigPass[idx];
  endfunction

endpackage

// File: rtl/dv_test_status_detector.sv
// Scans a console byte stream for the whole-line signatures
// "TEST PASSED CHECKS" / "TEST FAILED CHECKS" and latches a sticky verdict.
//
// state      | meaning
// -----------+--------------------------------------------------------
// LINE_START | at the first byte of a line
// MATCH      | idx characters of a signature matched so far
// CONFIRM    | full signature matched; next byte must end the line
// SKIP_LINE  | line cannot match; discard bytes up to '\n'
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   byte_valid_i   byte_i holds a character
//   byte_i         ASCII character
//   byte_ready_o   always 1 after reset (no back-pressure)
//   done_o         sticky: verdict latched
//   passed_o       sticky: verdict is PASSED
//   failed_o       sticky: verdict is FAILED
//   multi_o        sticky: another full signature seen after done_o
//   timeout_o      sticky: watchdog expired before done_o
//   line_cnt_o     accepted '\n' count, saturating
module dv_test_status_detector
  import dv_test_status_sig_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 0,
  parameter int unsigned LineCntW      = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                byte_valid_i,
  input  logic [7:0]          byte_i,
  output logic                byte_ready_o,
  output logic                done_o,
  output logic                passed_o,
  output logic                failed_o,
  output logic                multi_o,
  output logic                timeout_o,
  output logic [LineCntW-1:0] line_cnt_o
);

  localparam logic [4:0] IdxLast   = 5'(SigLen - 1);
  localparam logic [4:0] IdxBranch = 5'(BranchPos);

  det_state_e          state_q, state_d;
  logic [4:0]          idx_q, idx_d;
  logic                br_q, br_d;
  logic                ready_q;
  logic                done_q, passed_q, failed_q, multi_q;
  logic [LineCntW-1:0] line_cnt_q;

  logic accept, is_lf, is_cr;
  logic char_ok, br_sel;
  logic verdict_hit, lf_seen;

  assign accept = byte_valid_i && ready_q;
  assign is_lf  = (byte_i == AsciiLf);
  assign is_cr  = (byte_i == AsciiCr);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LINE_START;
      idx_q   <= 5'd0;
      br_q    <= BrPass;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      br_q    <= br_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    br_d    = br_q;
    char_ok = 1'b0;
    br_sel  = br_q;

    // The branch position accepts either letter and picks the signature.
    if (idx_q == IdxBranch) begin
      char_ok = (byte_i == SigPass[BranchPos]) || (byte_i == SigFail[BranchPos]);
      br_sel  = (byte_i == SigFail[BranchPos]) ? BrFail : BrPass;
    end else begin
      char_ok = (byte_i == sig_char(br_q, idx_q));
    end

    if (accept) begin
      case (state_q)
        LINE_START: begin
          if (byte_i == sig_char(BrPass, 5'd0)) begin
            state_d = MATCH;
            idx_d   = 5'd1;
          end else if (!is_lf) begin
            state_d = SKIP_LINE;
          end
        end
        MATCH: begin
          if (char_ok) begin
            br_d  = br_sel;
            idx_d = idx_q + 5'd1;
            if (idx_q == IdxLast) state_d = CONFIRM;
          end else begin
            idx_d   = 5'd0;
            state_d = is_lf ? LINE_START : SKIP_LINE;
          end
        end
        CONFIRM: begin
          // '\r' still registers the verdict but the line ends at '\n'.
          idx_d   = 5'd0;
          state_d = is_lf ? LINE_START : SKIP_LINE;
        end
        SKIP_LINE: begin
          if (is_lf) state_d = LINE_START;
        end
        default: begin
          idx_d   = 5'd0;
          state_d = LINE_START;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    verdict_hit = accept && (state_q == CONFIRM) && (is_lf || is_cr);
    lf_seen     = accept && is_lf;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      passed_q   <= 1'b0;
      failed_q   <= 1'b0;
      multi_q    <= 1'b0;
      line_cnt_q <= '0;
    end else begin
      ready_q <= 1'b1;
      if (verdict_hit) begin
        if (!done_q) begin
          done_q   <= 1'b1;
          passed_q <= (br_q == BrPass);
          failed_q <= (br_q == BrFail);
        end else begin
          multi_q <= 1'b1;
        end
      end
      if (lf_seen && (line_cnt_q != '1)) line_cnt_q <= line_cnt_q + LineCntW'(1);
    end
  end

  generate
    if (TimeoutCycles > 0) begin : g_wdog
      localparam int unsigned WdW = $clog2(TimeoutCycles + 1);
      logic [WdW-1:0] wd_cnt_q;
      logic           timeout_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          wd_cnt_q  <= '0;
          timeout_q <= 1'b0;
        end else if (!done_q && !timeout_q) begin
          wd_cnt_q <= wd_cnt_q + WdW'(1);
          if (wd_cnt_q == WdW'(TimeoutCycles - 1)) timeout_q <= 1'b1;
        end
      end

      assign timeout_o = timeout_q;
    end else begin : g_no_wdog
      assign timeout_o = 1'b0;
    end
  endgenerate

  assign byte_ready_o = ready_q;
  assign done_o       = done_q;
  assign passed_o     = passed_q;
  assign failed_o     = failed_q;
  assign multi_o      = multi_q;
  assign line_cnt_o   = line_cnt_q;

endmodule

// File: tb/tb_dv_test_status_detector.sv
// Bench for dv_test_status_detector. dut0 has the watchdog disabled,
// dut1 uses TimeoutCycles=100; both see the same byte stream.
module tb_dv_test_status_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bvalid = 1'b0;
  logic [7:0] bdata = 8'h00;

  logic        rdy0, done0, pass0, fail0, multi0, to0;
  logic [15:0] lc0;
  logic        rdy1, done1, pass1, fail1, multi1, to1;
  logic [15:0] lc1;

  typedef struct packed {
    logic        rdy, done, passed, failed, multi, timeout;
    logic [15:0] lc;
  } status_t;

  typedef struct {
    string   name;
    status_t v;
  } exp_t;

  exp_t    sb[$];
  exp_t    e;
  status_t o;
  int      vectors = 0;
  int      errors  = 0;

  always #5 clk = ~clk;

  dv_test_status_detector dut0 (
    .clk_i(clk), .rst_i(rst), .byte_valid_i(bvalid), .byte_i(bdata),
    .byte_ready_o(rdy0), .done_o(done0), .passed_o(pass0), .failed_o(fail0),
    .multi_o(multi0), .timeout_o(to0), .line_cnt_o(lc0)
  );

  dv_test_status_detector #(.TimeoutCycles(100)) dut1 (
    .clk_i(clk), .rst_i(rst), .byte_valid_i(bvalid), .byte_i(bdata),
    .byte_ready_o(rdy1), .done_o(done1), .passed_o(pass1), .failed_o(fail1),
    .multi_o(multi1), .timeout_o(to1), .line_cnt_o(lc1)
  );

  function automatic status_t mk(input logic r, input logic d, input logic p, input logic f,
                                 input logic m, input logic t, input int lc);
    mk = {r, d, p, f, m, t, 16'(lc)};
  endfunction

  function automatic status_t st(input bit which);
    if (which) st = {rdy1, done1, pass1, fail1, multi1, to1, lc1};
    else       st = {rdy0, done0, pass0, fail0, multi0, to0, lc0};
  endfunction

  function automatic exp_t ex(input string n, input status_t v);
    ex.name = n;
    ex.v    = v;
  endfunction

  // Inputs change just after the falling edge; outputs are read there too.
  task automatic send_byte(input logic [7:0] b);
    bvalid = 1'b1;
    bdata  = b;
    @(negedge clk);
    bvalid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_reset();
    bvalid = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bvalid = 1'b0;
    rst    = 1'b1;
    sb.push_back(ex("reset_active", mk(0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    e = sb.pop_front(); o = st(0); vectors++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got flags=%b lines=%0d, expected flags=%b lines=%0d", e.name, o[21:16], o.lc, e.v[21:16], e.v.lc);
    end
    rst = 1'b0;
    sb.push_back(ex("reset_released", mk(1, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    e = sb.pop_front(); o = st(0); vectors++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got flags=%b lines=%0d, expected flags=%b lines=%0d", e.name, o[21:16], o.lc, e.v[21:16], e.v.lc);
    end
  endtask

  task automatic test_pass();
    do_reset();
    sb.push_back(ex("pass_line", mk(1, 1, 1, 0, 0, 0, 2)));
    send_str("\nTEST PASSED CHECKS\n");
    e = sb.pop_front(); o = st(0); vectors++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got flags=%b lines=%0d, expected flags=%b lines=%0d", e.name, o[21:16], o.lc, e.v[21:16], e.v.lc);
    end
  endtask

  task automatic test_fail_cr();
    do_reset();
    // Verdict must already be visible right after the '\r' is accepted.
    sb.push_back(ex("fail_cr_latency", mk(1, 1, 0, 1, 0, 0, 0)));
    sb.push_back(ex("fail_cr_line", mk(1, 1, 0, 1, 0, 0, 1)));
    send_str("TEST FAILED CHECKS\r");
    e = sb.pop_front(); o = st(0); vectors++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got flags=%b lines=%0d, expected flags=%b lines=%0d", e.name, o[21:16], o.lc, e.v[21:16], e.v.lc);
    end
    send_str("\n");
    e = sb.pop_front(); o = st(0); vectors++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got flags=%b lines=%0d, expected flags=%b lines=%0d", e.name, o[21:16], o.lc, e.v[21:16], e.v.lc);
    end
  endtask

  task automatic test_near_miss();
    string lines[4];
    lines[0] = "TEST PASSED CHECKSX\n";
    lines[1] = " TEST PASSED CHECKS\n";
    lines[2] = "TEST PASSEX CHECKS\n";
    lines[3] = "xTEST FAILED CHECKS\n";
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sb.push_back(ex($sformatf("near_miss_%0d", i), mk(1, 0, 0, 0, 0, 0, i + 1)));
      send_str(lines[i]);
      e = sb.pop_front(); o = st(0); vectors++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: got flags=%b lines=%0d, expected flags=%b lines=%0d", e.name, o[21:16], o.lc, e.v[21:16], e.v.lc);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    sb.push_back(ex("first_verdict", mk(1, 1, 1, 0, 0, 0, 1)));
    sb.push_back(ex("double_signature", mk(1, 1, 1, 0, 1, 0, 2)));
    send_str("TEST PASSED CHECKS\n");
    e = sb.pop_front(); o = st(0); vectors++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got flags=%b lines=%0d, expected flags=%b lines=%0d", e.name, o[21:16], o.lc, e.v[21:16], e.v.lc);
    end
    send_str("TEST FAILED CHECKS\n");
    e = sb.pop_front(); o = st(0); vectors++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got flags=%b lines=%0d, expected flags=%b lines=%0d", e.name, o[21:16], o.lc, e.v[21:16], e.v.lc);
    end
  endtask

  task automatic test_watchdog();
    string s;
    s = "TEST PASSED CHECKS\n";
    bvalid = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(ex("wdog_cycle99", mk(1, 0, 0, 0, 0, 0, 0)));
    sb.push_back(ex("wdog_cycle100", mk(1, 0, 0, 0, 0, 1, 0)));
    repeat (99) @(negedge clk);
    e = sb.pop_front(); o = st(1); vectors++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got flags=%b lines=%0d, expected flags=%b lines=%0d", e.name, o[21:16], o.lc, e.v[21:16], e.v.lc);
    end
    @(negedge clk);
    e = sb.pop_front(); o = st(1); vectors++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got flags=%b lines=%0d, expected flags=%b lines=%0d", e.name, o[21:16], o.lc, e.v[21:16], e.v.lc);
    end
    sb.push_back(ex("wdog_late_pass", mk(1, 1, 1, 0, 0, 1, 1)));
    sb.push_back(ex("wdog_disabled", mk(1, 1, 1, 0, 0, 0, 1)));
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    e = sb.pop_front(); o = st(1); vectors++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got flags=%b lines=%0d, expected flags=%b lines=%0d", e.name, o[21:16], o.lc, e.v[21:16], e.v.lc);
    end
    e = sb.pop_front(); o = st(0); vectors++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got flags=%b lines=%0d, expected flags=%b lines=%0d", e.name, o[21:16], o.lc, e.v[21:16], e.v.lc);
    end
  endtask

  task automatic test_reset_mid_line();
    do_reset();
    sb.push_back(ex("mid_pre_reset", mk(1, 1, 1, 0, 0, 0, 1)));
    sb.push_back(ex("mid_in_reset", mk(0, 0, 0, 0, 0, 0, 0)));
    sb.push_back(ex("mid_after_reset", mk(1, 0, 0, 0, 0, 0, 0)));
    sb.push_back(ex("mid_tail_line", mk(1, 0, 0, 0, 0, 0, 1)));
    send_str("TEST PASSED CHECKS\nTEST PASS");
    e = sb.pop_front(); o = st(0); vectors++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got flags=%b lines=%0d, expected flags=%b lines=%0d", e.name, o[21:16], o.lc, e.v[21:16], e.v.lc);
    end
    rst = 1'b1;
    @(negedge clk);
    e = sb.pop_front(); o = st(0); vectors++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got flags=%b lines=%0d, expected flags=%b lines=%0d", e.name, o[21:16], o.lc, e.v[21:16], e.v.lc);
    end
    rst = 1'b0;
    @(negedge clk);
    e = sb.pop_front(); o = st(0); vectors++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got flags=%b lines=%0d, expected flags=%b lines=%0d", e.name, o[21:16], o.lc, e.v[21:16], e.v.lc);
    end
    send_str("ED CHECKS\n");
    e = sb.pop_front(); o = st(0); vectors++;
    if (o !== e.v) begin
      errors++;
      $display("FAIL %s: got flags=%b lines=%0d, expected flags=%b lines=%0d", e.name, o[21:16], o.lc, e.v[21:16], e.v.lc);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_pass();
    test_fail_cr();
    test_near_miss();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_line();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
